// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   barrel_mode_e      shift/rotate mode encodings (5-7 are reserved)
//   is_reserved_mode() true for any encoding outside the defined modes
package barrel_pkg;

    typedef enum logic [2:0] {
        MODE_LSL = 3'd0,
        MODE_LSR = 3'd1,
        MODE_ASR = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } barrel_mode_e;

    function automatic logic is_reserved_mode(input logic [2:0] mode);
        return mode > 3'(MODE_ROR);
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One register stage of the barrel shifter pipeline.
// Applies a shift/rotate by 2^STAGE_IDX when amt_i[STAGE_IDX] is set and
// registers the result together with the sideband fields.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   valid_i/ready_o                  upstream handshake
//   data_i, amt_i, mode_i, tag_i, err_i   beat fields from the previous stage
//   valid_o/ready_i                  downstream handshake
//   data_o, amt_o, mode_o, tag_o, err_o   registered beat fields
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGE_IDX = 0,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    input  logic [2:0]               mode_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic                     err_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH)-1:0] amt_o,
    output logic [2:0]               mode_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic                     err_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int D   = 1 << STAGE_IDX;

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   amt_q;
    logic [2:0]       mode_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;
    logic             load;

    // An empty stage always accepts, so bubbles never stall the stage behind it.
    assign load    = !valid_q || ready_i;
    assign ready_o = load;

    always_comb begin
        data_d = data_i;
        if (amt_i[STAGE_IDX] && !err_i) begin
            case (mode_i)
                MODE_LSL: data_d = {data_i[WIDTH-1-D:0], {D{1'b0}}};
                MODE_LSR: data_d = {{D{1'b0}}, data_i[WIDTH-1:D]};
                MODE_ASR: data_d = {{D{data_i[WIDTH-1]}}, data_i[WIDTH-1:D]};
                MODE_ROL: data_d = {data_i[WIDTH-1-D:0], data_i[WIDTH-1:WIDTH-D]};
                MODE_ROR: data_d = {data_i[D-1:0], data_i[WIDTH-1:D]};
                default:  data_d = data_i;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else if (load) begin
            valid_q <= valid_i;
            // Payload only moves with a real beat so idle slots do not toggle.
            if (valid_i) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                mode_q <= mode_i;
                tag_q  <= tag_i;
                err_q  <= err_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign mode_o  = mode_q;
    assign tag_o   = tag_q;
    assign err_o   = err_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages, stage k shifts by
// 2^k when bit k of the amount is set. Valid/ready on both sides, TAG sideband.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              input handshake
//   in_data, in_amt, in_mode, in_tag   operand, amount, mode (0-4, 5-7 reserved), tag
//   out_valid/out_ready            output handshake
//   out_data, out_tag              result and its tag
//   out_zero                       out_data == 0 (only while out_valid)
//   out_err                        beat carried a reserved mode
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero,
    output logic                     out_err
);

    localparam int SHW = $clog2(WIDTH);

    // Index 0 is the pipeline input; index k+1 is the output of stage k.
    logic [SHW:0]     vld;
    logic [SHW:0]     rdy;
    logic [SHW:0]     err;
    logic [WIDTH-1:0] dat [SHW+1];
    logic [SHW-1:0]   amt [SHW+1];
    logic [2:0]       mod [SHW+1];
    logic [TAG_W-1:0] tag [SHW+1];

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign amt[0] = in_amt;
    assign mod[0] = in_mode;
    assign tag[0] = in_tag;
    assign err[0] = is_reserved_mode(in_mode);

    assign rdy[SHW] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(
            .WIDTH     (WIDTH),
            .STAGE_IDX (k),
            .TAG_W     (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (vld[k]),
            .ready_o (rdy[k]),
            .data_i  (dat[k]),
            .amt_i   (amt[k]),
            .mode_i  (mod[k]),
            .tag_i   (tag[k]),
            .err_i   (err[k]),
            .valid_o (vld[k+1]),
            .ready_i (rdy[k+1]),
            .data_o  (dat[k+1]),
            .amt_o   (amt[k+1]),
            .mode_o  (mod[k+1]),
            .tag_o   (tag[k+1]),
            .err_o   (err[k+1])
        );
    end

    // Amount and mode are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{amt[SHW], mod[SHW]};

    assign out_valid = vld[SHW];
    assign out_data  = dat[SHW];
    assign out_tag   = tag[SHW];
    assign out_err   = err[SHW];
    assign out_zero  = vld[SHW] && (dat[SHW] == '0);

endmodule
